// File: rtl/onehot_monitor.sv
// Watches a 3-bit one-hot up counter. Reports the binary index of the hot
// bit, flags illegal encodings and out-of-order steps, and counts completed
// 100 -> 001 rotations.
module onehot_monitor #(
  parameter int WRAP_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              q0,
  input  logic              q1,
  input  logic              q2,
  input  logic              clear,
  output logic [1:0]        bin,
  output logic              valid,
  output logic              hot_err,
  output logic              seq_err,
  output logic [WRAP_W-1:0] wraps,
  output logic              wrap_pulse
);

  typedef enum logic [1:0] {SYNC, TRACK, FAULT} state_t;

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_s, r_p;
  logic [1:0]        r_bin, w_bin_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_hot, w_hot_nxt;
  logic              r_seq, w_seq_nxt;
  logic [WRAP_W-1:0] r_wraps, w_wraps_nxt;
  logic              r_pulse, w_pulse_nxt;
  logic              w_legal;
  logic [2:0]        w_succ;

  function automatic logic [1:0] enc(input logic [2:0] v);
    case (v)
      3'b010:  enc = 2'd1;
      3'b100:  enc = 2'd2;
      default: enc = 2'd0;
    endcase
  endfunction

  assign w_legal = (r_s == 3'b001) || (r_s == 3'b010) || (r_s == 3'b100);
  assign w_succ  = {r_p[1:0], r_p[2]};

  // Two-deep sample pipeline; keeps running through clear so history is fresh.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s <= 3'b000;
      r_p <= 3'b000;
    end else begin
      r_s <= {q2, q1, q0};
      r_p <= r_s;
    end
  end

  // Next-state and next-output decode; clear overrides every other outcome.
  always_comb begin
    w_state_nxt = r_state;
    w_bin_nxt   = r_bin;
    w_valid_nxt = r_valid;
    w_hot_nxt   = r_hot;
    w_seq_nxt   = r_seq;
    w_wraps_nxt = r_wraps;
    w_pulse_nxt = 1'b0;
    if (clear) begin
      w_state_nxt = SYNC;
      w_bin_nxt   = 2'd0;
      w_valid_nxt = 1'b0;
      w_hot_nxt   = 1'b0;
      w_seq_nxt   = 1'b0;
      w_wraps_nxt = '0;
    end else begin
      case (r_state)
        SYNC: begin
          if (w_legal) begin
            w_state_nxt = TRACK;
            w_bin_nxt   = enc(r_s);
            w_valid_nxt = 1'b1;
          end
        end
        TRACK: begin
          if (!w_legal) begin
            w_hot_nxt   = 1'b1;
            w_valid_nxt = 1'b0;
            w_state_nxt = FAULT;
          end else if (r_s == r_p) begin
            // hold: nothing moves
          end else if (r_s == w_succ) begin
            w_bin_nxt = enc(r_s);
            if (r_p == 3'b100) begin
              w_wraps_nxt = r_wraps + WRAP_W'(1);
              w_pulse_nxt = 1'b1;
            end
          end else begin
            w_seq_nxt   = 1'b1;
            w_valid_nxt = 1'b0;
            w_state_nxt = FAULT;
          end
        end
        default: begin
          // FAULT is terminal until clear or reset
          w_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= SYNC;
      r_bin   <= 2'd0;
      r_valid <= 1'b0;
      r_hot   <= 1'b0;
      r_seq   <= 1'b0;
      r_wraps <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bin   <= w_bin_nxt;
      r_valid <= w_valid_nxt;
      r_hot   <= w_hot_nxt;
      r_seq   <= w_seq_nxt;
      r_wraps <= w_wraps_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  assign bin        = r_bin;
  assign valid      = r_valid;
  assign hot_err    = r_hot;
  assign seq_err    = r_seq;
  assign wraps      = r_wraps;
  assign wrap_pulse = r_pulse;

endmodule

// File: tb/tb_onehot_monitor.sv
// Directed bench for onehot_monitor: a behavioural model checked every cycle,
// plus hand-computed checkpoints along each scenario.
module tb_onehot_monitor;

  localparam int WRAP_W = 4;
  localparam int WMOD   = 1 << WRAP_W;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic q0 = 1'b0, q1 = 1'b0, q2 = 1'b0;
  logic clear = 1'b0;
  logic [1:0]        bin;
  logic              valid, hot_err, seq_err, wrap_pulse;
  logic [WRAP_W-1:0] wraps;

  int n_tests = 0;
  int n_fail  = 0;

  onehot_monitor #(.WRAP_W(WRAP_W)) dut (
    .clock(clock), .reset(reset), .q0(q0), .q1(q1), .q2(q2), .clear(clear),
    .bin(bin), .valid(valid), .hot_err(hot_err), .seq_err(seq_err),
    .wraps(wraps), .wrap_pulse(wrap_pulse)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = waiting for a legal sample, 1 = tracking, 2 = faulted
  int       m_mode = 0;
  logic [2:0] m_s = 3'b000, m_p = 3'b000;
  int m_bin = 0, m_valid = 0, m_hot = 0, m_seq = 0, m_wraps = 0, m_pulse = 0;

  function automatic int pos(input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_s = 3'b000; m_p = 3'b000;
      m_bin = 0; m_valid = 0; m_hot = 0; m_seq = 0; m_wraps = 0; m_pulse = 0;
    end else begin
      m_pulse = 0;
      if (clear) begin
        m_mode = 0; m_bin = 0; m_valid = 0; m_hot = 0; m_seq = 0; m_wraps = 0;
      end else if (m_mode == 0) begin
        if ($countones(m_s) == 1) begin
          m_mode = 1; m_bin = pos(m_s); m_valid = 1;
        end
      end else if (m_mode == 1) begin
        if ($countones(m_s) != 1) begin
          m_hot = 1; m_valid = 0; m_mode = 2;
        end else if (m_s != m_p) begin
          if (pos(m_s) == (pos(m_p) + 1) % 3) begin
            m_bin = pos(m_s);
            if (pos(m_p) == 2) begin
              m_wraps = (m_wraps + 1) % WMOD;
              m_pulse = 1;
            end
          end else begin
            m_seq = 1; m_valid = 0; m_mode = 2;
          end
        end
      end else begin
        m_valid = 0;
      end
      m_p = m_s;
      m_s = {q2, q1, q0};
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    check("cyc_bin",   int'(bin),        m_bin);
    check("cyc_valid", int'(valid),      m_valid);
    check("cyc_hot",   int'(hot_err),    m_hot);
    check("cyc_seq",   int'(seq_err),    m_seq);
    check("cyc_wraps", int'(wraps),      m_wraps);
    check("cyc_pulse", int'(wrap_pulse), m_pulse);
  end

  // Present v to the upstream bits and let n rising edges sample it.
  task automatic drive(input logic [2:0] v, input int n);
    {q2, q1, q0} = v;
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_bin"},   int'(bin),        0);
    check({tag, "_valid"}, int'(valid),      0);
    check({tag, "_hot"},   int'(hot_err),    0);
    check({tag, "_seq"},   int'(seq_err),    0);
    check({tag, "_wraps"}, int'(wraps),      0);
    check({tag, "_pulse"}, int'(wrap_pulse), 0);
  endtask

  initial begin
    #1;
    all_zero("rst0");
    drive(3'b000, 2);
    all_zero("rst_held");
    #3 reset = 1'b0;

    // Start at 001: valid two edges after the first 001 sample.
    drive(3'b001, 1);
    check("first_valid_early", int'(valid), 0);
    drive(3'b001, 1);
    check("first_valid", int'(valid), 1);
    check("first_bin",   int'(bin),   0);

    // 18 rotation bodies cover wraps 15 -> 0 -> 1.
    for (int r = 1; r <= 18; r++) begin
      drive(3'b010, 1);
      if (r == 2)  check("wrap1_pulse", int'(wrap_pulse), 1);
      if (r == 17) begin
        check("wrap15to0_pulse", int'(wrap_pulse), 1);
        check("wrap15to0_val",   int'(wraps),      0);
      end
      drive(3'b100, 1);
      if (r == 2) check("bin_step1", int'(bin), 1);
      drive(3'b001, 1);
      if (r == 2)  check("bin_step2", int'(bin), 2);
      if (r == 16) check("wraps_15", int'(wraps), 15);
    end
    check("wraps_1_again", int'(wraps), 1);

    // Hold at 010 for 5 clocks.
    drive(3'b010, 5);
    check("hold_wraps", int'(wraps),   2);
    check("hold_bin",   int'(bin),     1);
    check("hold_valid", int'(valid),   1);
    check("hold_err",   int'(hot_err | seq_err), 0);

    // At 010 jump back to 001: sequence error.
    drive(3'b001, 1);
    drive(3'b010, 1);
    check("seq_err_set", int'(seq_err), 1);
    check("seq_valid",   int'(valid),   0);
    check("seq_bin",     int'(bin),     1);
    drive(3'b100, 2);
    check("fault_stays", int'(seq_err), 1);
    clear = 1'b1;
    drive(3'b100, 1);
    clear = 1'b0;
    all_zero("clr");
    drive(3'b001, 1);
    check("resume_valid", int'(valid), 1);
    check("resume_bin",   int'(bin),   2);

    // Illegal 011 while tracking: hot error, sticky.
    drive(3'b011, 1);
    drive(3'b001, 1);
    check("hot_set",   int'(hot_err), 1);
    check("hot_valid", int'(valid),   0);
    drive(3'b010, 3);
    check("hot_sticky", int'(hot_err), 1);
    check("hot_sticky_valid", int'(valid), 0);

    // Re-sync and count up to 5 wraps, then reset between edges.
    clear = 1'b1;
    drive(3'b001, 1);
    clear = 1'b0;
    for (int g = 0; g < 40 && m_wraps != 5; g++) begin
      drive(3'b010, 1);
      drive(3'b100, 1);
      drive(3'b001, 1);
    end
    check("wraps_5", int'(wraps), 5);
    #1 reset = 1'b1;
    #1;
    all_zero("async_rst");
    drive(3'b010, 2);
    all_zero("async_rst_held");
    #1 reset = 1'b0;

    // Clear coincides with an illegal sample: flags stay clear.
    drive(3'b001, 2);
    drive(3'b010, 1);
    drive(3'b011, 1);
    clear = 1'b1;
    drive(3'b001, 1);
    clear = 1'b0;
    check("clr_err_hot", int'(hot_err), 0);
    check("clr_err_seq", int'(seq_err), 0);
    check("clr_err_valid", int'(valid), 0);
    drive(3'b001, 2);
    check("after_clr_valid", int'(valid), 1);

    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
